// File: rtl/vga_read_requester_if.sv
// SDRAM read-port bundle between the VGA read requester and the memory side.
// The requester drives the request/address pair; the memory side answers with
// a stall and one returned-datum strobe per cycle.
interface vga_read_requester_if;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic        rd_waitrequest;
  logic        readValid;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_waitrequest,
    input  readValid
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_waitrequest,
    output readValid
  );
endinterface

// File: rtl/vga_read_requester.sv
// VGA read requester: walks a pixel pointer over the frame and launches one
// SDRAM read per pixel at readOffset + pointer.  Issue is throttled by the
// number of reads still in flight and by how full the PortV output FIFO is.
// A shadow copy of the PortV tracker's pixel position is kept so that, when
// the tracker starts filling with null pixels, the request pointer can be
// re-aimed a fixed distance ahead of it and returned data lines up again.
module vga_read_requester #(
  parameter int unsigned FRAME_PIXELS    = 307200,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned FIFO_HIGH       = 480,
  parameter int unsigned SKIP_AHEAD      = 16
) (
  input  logic                        clk,
  input  logic                        portV_arst_n,
  input  logic [24:0]                 readOffset,
  input  logic [8:0]                  PortVout_usedw,
  input  logic                        PortVout_wrreq,
  input  logic                        PortVout_nullData,
  vga_read_requester_if.master        rd_bus,
  output logic [3:0]                  outstanding
);

  localparam logic [19:0] FRAME_P = 20'(FRAME_PIXELS);
  localparam logic [19:0] SKIP_P  = 20'(SKIP_AHEAD);
  localparam logic [3:0]  MAX_P   = 4'(MAX_OUTSTANDING);
  localparam logic [9:0]  HIGH_P  = 10'(FIFO_HIGH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        rd_req_q, rd_req_d;
  logic [24:0] rd_addr_q, rd_addr_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [18:0] req_ptr_q, req_ptr_d;
  logic [18:0] trk_ptr_q, trk_ptr_d;
  logic        resync_pend_q, resync_pend_d;

  logic        accept;
  logic        read_return;
  logic        null_pulse;
  logic        resync_want;
  logic [18:0] req_ptr_inc;
  logic [18:0] resync_ptr;

  // Fold a pointer sum back into the frame.  Callers only ever pass values
  // below twice the frame size, so a single subtraction is enough.
  function automatic logic [18:0] wrap_ptr(input logic [19:0] x);
    logic [19:0] y;
    y = x;
    if (x >= FRAME_P) begin
      y = x - FRAME_P;
    end
    return y[18:0];
  endfunction

  // Room to issue another read: a free outstanding slot, and the FIFO fill
  // plus everything already in flight stays under the high-water mark.
  function automatic logic has_credit(input logic [3:0] cnt,
                                      input logic [8:0] usedw);
    logic [9:0] level;
    level = {1'b0, usedw} + {6'd0, cnt};
    return (cnt < MAX_P) && (level < HIGH_P);
  endfunction

  // Next-state, pointer, counter and request logic for the issue FSM.
  always_comb begin
    state_d       = state_q;
    rd_req_d      = rd_req_q;
    rd_addr_d     = rd_addr_q;
    req_ptr_d     = req_ptr_q;

    accept        = rd_req_q & ~rd_bus.rd_waitrequest;
    read_return   = rd_bus.readValid & (outstanding_q != 4'd0);
    outstanding_d = outstanding_q + {3'd0, accept} - {3'd0, read_return};

    trk_ptr_d     = trk_ptr_q;
    if (PortVout_wrreq) begin
      trk_ptr_d = wrap_ptr({1'b0, trk_ptr_q} + 20'd1);
    end

    null_pulse    = PortVout_wrreq & PortVout_nullData;
    resync_want   = resync_pend_q | null_pulse;
    resync_pend_d = resync_want;

    req_ptr_inc   = wrap_ptr({1'b0, req_ptr_q} + 20'd1);
    resync_ptr    = wrap_ptr({1'b0, trk_ptr_d} + SKIP_P);

    case (state_q)
      IDLE: begin
        if (resync_want) begin
          req_ptr_d     = resync_ptr;
          resync_pend_d = 1'b0;
        end else if (has_credit(outstanding_q, PortVout_usedw)) begin
          state_d   = REQ;
          rd_req_d  = 1'b1;
          rd_addr_d = readOffset + {6'd0, req_ptr_q};
        end
      end

      REQ: begin
        if (accept) begin
          if (resync_want) begin
            req_ptr_d     = resync_ptr;
            resync_pend_d = 1'b0;
            state_d       = IDLE;
            rd_req_d      = 1'b0;
          end else begin
            req_ptr_d = req_ptr_inc;
            if (has_credit(outstanding_d, PortVout_usedw)) begin
              rd_addr_d = readOffset + {6'd0, req_ptr_inc};
            end else begin
              state_d  = IDLE;
              rd_req_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d  = IDLE;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // State register; reset drops any pending request immediately.
  always_ff @(posedge clk or negedge portV_arst_n) begin
    if (!portV_arst_n) begin
      state_q       <= IDLE;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= 25'd0;
      outstanding_q <= 4'd0;
      req_ptr_q     <= 19'd0;
      trk_ptr_q     <= 19'd0;
      resync_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      outstanding_q <= outstanding_d;
      req_ptr_q     <= req_ptr_d;
      trk_ptr_q     <= trk_ptr_d;
      resync_pend_q <= resync_pend_d;
    end
  end

  assign rd_bus.rd_req  = rd_req_q;
  assign rd_bus.rd_addr = rd_addr_q;
  assign outstanding    = outstanding_q;

endmodule

// File: doc/vga_read_requester.md
Name: vga_read_requester

Overview:
- Upstream neighbour of the PortV address tracker.
- Issues sequential SDRAM read requests for VGA pixels at readOffset + pixel index, wrapping over the 640x480 frame.
- Flow control: bounded outstanding-read count and output-FIFO credit.
- Mirrors the tracker's pixel position; when the tracker emits null data, re-aims requests ahead of it so returned reads land on the tracker's expected address.

Parameters:
FRAME_PIXELS, 307200, pixels per frame; pixel index wraps to 0 after FRAME_PIXELS-1
MAX_OUTSTANDING, 8, maximum accepted-but-unreturned reads (1..15)
FIFO_HIGH, 480, issue only while PortVout_usedw + outstanding < FIFO_HIGH
SKIP_AHEAD, 16, pixels the request pointer is placed ahead of the tracker on resync (< FRAME_PIXELS)

Ports:
clk  input  1  system clock, all logic on rising edge
portV_arst_n  input  1  asynchronous active-low reset
readOffset  input  25  frame base address in SDRAM
PortVout_usedw  input  9  PortV output FIFO fill level
PortVout_wrreq  input  1  tracker writes FIFO this cycle (tracker advances one pixel)
PortVout_nullData  input  1  qualifies PortVout_wrreq: dummy pixel written
readValid  input  1  one SDRAM read datum returned this cycle
rd_waitrequest  input  1  SDRAM port stalls the current request
rd_req  output  1  read request
rd_addr  output  25  read address, stable while rd_req & rd_waitrequest
outstanding  output  4  current outstanding-read count

Behaviour:
- Reset (portV_arst_n low, asynchronous): rd_req=0, rd_addr=0, outstanding=0, req_ptr=0, trk_ptr=0, resync_pend=0, state IDLE. Release takes effect on next rising edge.
- Pointer wrap: wrap(x) = x - FRAME_PIXELS when x >= FRAME_PIXELS. Pointers are 19 bits.
- rd_addr = readOffset + {6'd0, req_ptr}, 25-bit modulo 2^25. Computed and registered when a request is launched. readOffset changes never alter an in-flight rd_addr.
- credit = (outstanding < MAX_OUTSTANDING) & ({1'b0,PortVout_usedw} + outstanding < FIFO_HIGH). Compare is 10-bit.
- State machine:
  - IDLE: if credit and not resync_pend, go to REQ. Register rd_req=1 and rd_addr the same edge, so there is one cycle from credit to rd_req.
  - REQ: hold rd_req, rd_addr.
    - While rd_waitrequest=1, stay in REQ; nothing changes.
    - Accept is rd_req & ~rd_waitrequest. On accept: outstanding+1, req_ptr = wrap(req_ptr+1).
    - After accept, if credit (evaluated with the post-accept count) and no resync pending, stay in REQ with the next address (back-to-back, one request per cycle). Otherwise go to IDLE with rd_req=0.
- Outstanding update:
  - +1 on accept, -1 on readValid; both in the same cycle leaves it unchanged.
  - readValid with outstanding=0 is ignored (saturate at 0).
  - Never exceeds MAX_OUTSTANDING.
- Tracker mirror: on PortVout_wrreq, trk_ptr = wrap(trk_ptr+1). This matches the tracker, which advances on both real and null writes.
- Resync: on PortVout_wrreq & PortVout_nullData, set resync_pend=1.
  - Applied when no request is being held: in IDLE, or in the same edge as an accept.
  - Effect: req_ptr = wrap(trk_ptr_next + SKIP_AHEAD), where trk_ptr_next includes that cycle's increment. resync_pend clears.
  - A held request (rd_waitrequest=1) is never modified.
  - Multiple null writes before application collapse into one resync using the latest trk_ptr.
- In-flight reads issued before a resync still return and decrement outstanding. Their data is discarded downstream; no special handling here.
- Reset mid-request drops rd_req immediately (asynchronous); outstanding returns to 0.

Test Plan:
- Reset, readOffset=0x100, usedw=0, waitrequest=0, no readValid → rd_req from second edge after release; addresses 0x100..0x107 on 8 consecutive accepts; then rd_req=0, outstanding=8.
- Same setup plus one readValid per cycle after the 8th accept → one new request per freed slot; outstanding stays 8. readValid coincident with accept holds the count.
- rd_waitrequest=1 for 5 cycles during a request while readOffset changes → rd_addr and rd_req unchanged all 5 cycles; single accept; req_ptr +1 only.
- usedw=475, outstanding=4 (475+4 < 480) → one request issued; after accept (479+1=480) no further rd_req until usedw drops.
- req_ptr at 307199 accepted with readOffset=0 → next rd_addr=0; tracker mirror wraps identically after 307200 wrreq pulses.
- trk_ptr=100, null write pulse while in IDLE → next rd_addr = readOffset+117. Same pulse during a held request → held address unchanged; after accept next address = readOffset + trk_ptr + SKIP_AHEAD.
